// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes NUM_BURSTS seeded bursts, reads them back and
// compares. One burst in flight at a time; reports error count and first bad address.
module axi_mem_tester #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 256,
  parameter int          BURST_LEN  = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         start,
  input  logic [31:0]  seed,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [31:0]  err_addr,
  // write address / data / response
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic [3:0]   awregion,
  output logic [3:0]   awqos,
  output logic         awvalid,
  input  logic         awready,
  output logic [127:0] wdata,
  output logic [15:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  // read address / data
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic [3:0]   arregion,
  output logic [3:0]   arqos,
  output logic         arvalid,
  input  logic         arready,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_RADDR = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [3:0]  LAST_BEAT   = 4'(BURST_LEN - 1);
  localparam logic [15:0] LAST_IDX    = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 16);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        pass_q, pass_d;

  logic [31:0]  burst_addr;
  logic [31:0]  beat_word;
  logic [127:0] pattern;
  logic         inc_err;

  assign burst_addr = BASE_ADDR + 32'(idx_q) * BURST_BYTES;
  assign beat_word  = seed_q ^ {idx_q, 12'd0, beat_q};
  assign pattern    = {4{beat_word}};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    seed_d     = seed_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    pass_d     = pass_q;
    inc_err    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_WADDR;
        idx_d      = '0;
        beat_d     = '0;
        seed_d     = seed;
        err_cnt_d  = '0;
        err_addr_d = '0;
        pass_d     = 1'b0;
      end
      S_WADDR: if (awready) state_d = S_WDATA;
      S_WDATA: if (wready) begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_WRESP;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_WRESP: if (bvalid) begin
        inc_err = (bresp != 2'b00);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_RADDR;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_WADDR;
        end
      end
      S_RADDR: if (arready) state_d = S_RDATA;
      S_RDATA: if (rvalid) begin
        // an early rlast is one error for the beat, not one per missing beat
        inc_err = (rdata != pattern) || (rresp != 2'b00) || (rlast && (beat_q != LAST_BEAT));
        if (inc_err && (err_cnt_q == 16'd0))
          err_addr_d = burst_addr + 32'({beat_q, 4'b0000});
        if (rlast) begin
          beat_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_RADDR;
          end
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_FIN: begin
        pass_d  = (err_cnt_q == 16'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (inc_err && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      beat_q     <= '0;
      seed_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      seed_q     <= seed_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      pass_q     <= pass_d;
    end
  end

  // every handshake output is a pure function of registered state
  assign awvalid = (state_q == S_WADDR);
  assign wvalid  = (state_q == S_WDATA);
  assign bready  = (state_q == S_WRESP);
  assign arvalid = (state_q == S_RADDR);
  assign rready  = (state_q == S_RDATA);
  assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done    = (state_q == S_FIN);
  assign pass    = done ? (err_cnt_q == 16'd0) : pass_q;

  assign err_count = err_cnt_q;
  assign err_addr  = err_addr_q;

  assign awaddr   = burst_addr;
  assign araddr   = burst_addr;
  assign wdata    = pattern;
  assign wlast    = (beat_q == LAST_BEAT);
  assign wstrb    = '1;
  assign awlen    = 8'(BURST_LEN - 1);
  assign arlen    = 8'(BURST_LEN - 1);
  assign awsize   = 3'd4;
  assign arsize   = 3'd4;
  assign awburst  = 2'b01;
  assign arburst  = 2'b01;
  assign awlock   = 1'b0;
  assign arlock   = 1'b0;
  assign awcache  = '0;
  assign arcache  = '0;
  assign awprot   = '0;
  assign arprot   = '0;
  assign awregion = '0;
  assign arregion = '0;
  assign awqos    = '0;
  assign arqos    = '0;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: memory-backed AXI slave with stall/fault injection,
// scoreboard queues filled from a pattern model, monitor compares at handshakes.
module tb_axi_mem_tester;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int NB = 2;
  localparam int BL = 4;

  logic aclk, aresetn, start;
  logic [31:0] seed;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] err_addr;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awregion, arregion, awqos, arqos;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb;

  axi_mem_tester #(.BASE_ADDR(BASE), .NUM_BURSTS(NB), .BURST_LEN(BL)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .err_addr(err_addr),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awregion(awregion), .awqos(awqos),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arregion(arregion), .arqos(arqos),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  typedef struct { logic [127:0] data; logic last; } wbeat_t;
  typedef struct { logic ok; logic [15:0] cnt; logic [31:0] addr; } res_t;

  logic [31:0] q_aw[$];
  logic [31:0] q_ar[$];
  wbeat_t      q_w[$];
  res_t        q_res[$];
  res_t        last_res;

  // slave fault selection; -1 disables
  int stall_en = 0;
  int corrupt_b = -1, corrupt_k = -1, bresp_b = -1, early_b = -1, early_k = -1;
  int w_total = 0;
  int done_total = 0;

  function automatic logic [127:0] pat(input logic [31:0] s, input int b, input int k);
    logic [31:0] w;
    w = s ^ {b[15:0], k[15:0]};
    return {4{w}};
  endfunction

  // reference: what the tester should emit and conclude for this seed and fault set
  task automatic expect_test(input logic [31:0] s);
    int cnt;
    logic [31:0] ea;
    res_t r;
    wbeat_t wb;
    cnt = 0;
    ea = '0;
    for (int b = 0; b < NB; b++) begin
      q_aw.push_back(BASE + 32'(b * BL * 16));
      for (int k = 0; k < BL; k++) begin
        wb.data = pat(s, b, k);
        wb.last = (k == BL - 1);
        q_w.push_back(wb);
      end
      if (bresp_b == b) cnt++;
    end
    for (int b = 0; b < NB; b++) begin
      q_ar.push_back(BASE + 32'(b * BL * 16));
      for (int k = 0; k < BL; k++) begin
        logic early, bad;
        early = (early_b == b) && (early_k == k);
        bad = early || ((corrupt_b == b) && (corrupt_k == k));
        if (bad) begin
          if (cnt == 0) ea = BASE + 32'(b * BL * 16 + k * 16);
          cnt++;
        end
        if (early) break;
      end
    end
    r.ok = (cnt == 0);
    r.cnt = 16'(cnt);
    r.addr = ea;
    q_res.push_back(r);
    last_res = r;
  endtask

  // slave: drive at negedge, then account for the handshakes the next posedge will take
  logic [127:0] mem [logic [31:0]];
  initial begin
    logic [31:0] wr_addr, rd_addr, a;
    int wr_k, rd_k, rd_b, b_burst;
    bit b_pend, rd_act;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
    wr_addr = '0; rd_addr = '0; wr_k = 0; rd_k = 0; rd_b = 0; b_burst = 0;
    b_pend = 0; rd_act = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        b_pend = 0; rd_act = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        continue;
      end
      awready = stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = b_pend;
      bresp   = (b_pend && bresp_b == b_burst) ? 2'b10 : 2'b00;
      if (rd_act) begin
        a = rd_addr + 32'(rd_k * 16);
        rvalid = stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        rdata  = mem.exists(a) ? mem[a] : '0;
        if (corrupt_b == rd_b && corrupt_k == rd_k) rdata = rdata ^ 128'h100;
        rlast  = (rd_k == BL - 1) || (early_b == rd_b && early_k == rd_k);
        rresp  = 2'b00;
      end else begin
        rvalid = 0;
        rlast = 0;
      end
      if (awvalid && awready) begin
        wr_addr = awaddr;
        wr_k = 0;
      end
      if (wvalid && wready) begin
        mem[wr_addr + 32'(wr_k * 16)] = wdata;
        wr_k++;
        if (wlast) begin
          b_pend = 1;
          b_burst = int'((wr_addr - BASE) / (BL * 16));
        end
      end
      if (bvalid && bready) b_pend = 0;
      if (arvalid && arready) begin
        rd_act = 1;
        rd_addr = araddr;
        rd_k = 0;
        rd_b = int'((araddr - BASE) / (BL * 16));
      end
      if (rvalid && rready) begin
        rd_k++;
        if (rlast) rd_act = 0;
      end
    end
  end

  // monitor: compare every handshake and done pulse against the scoreboard
  initial begin
    bit aw_hold, w_hold, ar_hold;
    logic [31:0] aw_prev, ar_prev;
    logic [128:0] w_prev;
    res_t r;
    wbeat_t wb;
    aw_hold = 0; w_hold = 0; ar_hold = 0;
    aw_prev = '0; ar_prev = '0; w_prev = '0;
    forever begin
      @(negedge aclk);
      #1;
      if (!aresetn) begin
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        continue;
      end
      if (aw_hold) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
      if (w_hold)  chk("w_stable", {wvalid, wlast, wdata}, {1'b1, w_prev});
      if (ar_hold) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
      aw_hold = awvalid && !awready; aw_prev = awaddr;
      w_hold  = wvalid && !wready;   w_prev  = {wlast, wdata};
      ar_hold = arvalid && !arready; ar_prev = araddr;
      if (awvalid && awready) begin
        if (q_aw.size() == 0) miss("aw_unexpected");
        else chk("awaddr", awaddr, q_aw.pop_front());
      end
      if (wvalid && wready) begin
        w_total++;
        if (q_w.size() == 0) miss("w_unexpected");
        else begin
          wb = q_w.pop_front();
          chk("wdata", wdata, wb.data);
          chk("wlast", wlast, wb.last);
        end
      end
      if (arvalid && arready) begin
        if (q_ar.size() == 0) miss("ar_unexpected");
        else chk("araddr", araddr, q_ar.pop_front());
      end
      if (done) begin
        done_total++;
        if (q_res.size() == 0) miss("done_unexpected");
        else begin
          r = q_res.pop_front();
          chk("pass", pass, r.ok);
          chk("err_count", err_count, r.cnt);
          chk("err_addr", err_addr, r.addr);
          chk("busy_at_done", busy, 1'b0);
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] s);
    @(negedge aclk);
    start = 1'b1;
    seed = s;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (q_res.size() == 0) break;
      @(negedge aclk);
    end
    if (i == 3000) begin
      miss("timeout_waiting_done");
      q_aw.delete(); q_w.delete(); q_ar.delete(); q_res.delete();
    end
    repeat (5) @(negedge aclk);
    chk("leftover_expected", 32'(q_aw.size() + q_w.size() + q_ar.size()), 32'd0);
    chk("pass_hold", pass, last_res.ok);
    chk("err_count_hold", err_count, last_res.cnt);
  endtask

  task automatic clear_faults();
    stall_en = 0; corrupt_b = -1; corrupt_k = -1; bresp_b = -1; early_b = -1; early_k = -1;
  endtask

  task automatic run(input logic [31:0] s);
    expect_test(s);
    pulse_start(s);
    wait_done();
  endtask

  initial begin
    logic [31:0] s;
    int base, i;
    aresetn = 1'b0;
    start = 1'b0;
    seed = '0;
    repeat (3) @(negedge aclk);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
    chk("rst_status", {busy, done, pass}, 3'd0);
    chk("rst_err_count", err_count, 16'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("const_len", {awlen, arlen}, {8'(BL - 1), 8'(BL - 1)});
    chk("const_size_burst", {awsize, arsize, awburst, arburst}, {3'd4, 3'd4, 2'b01, 2'b01});
    chk("const_wstrb", wstrb, 16'hFFFF);
    chk("const_attrs", {awlock, arlock, awcache, arcache, awprot, arprot,
                        awregion, arregion, awqos, arqos}, '0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // ideal slave, seed 0
    clear_faults();
    run(32'h0);
    // corrupted read beat: burst 1 beat 2
    clear_faults(); corrupt_b = 1; corrupt_k = 2;
    run(32'h0);
    // random handshake stalls
    clear_faults(); stall_en = 1;
    run(32'h0);
    // write response error on burst 0
    clear_faults(); bresp_b = 0;
    run(32'h1234_5678);
    // early rlast on burst 0 beat 1
    clear_faults(); early_b = 0; early_k = 1;
    run(32'hA5A5_0F0F);

    // asynchronous reset while the third write beat is presented
    clear_faults();
    s = 32'hDEAD_BEEF;
    expect_test(s);
    base = w_total;
    pulse_start(s);
    for (i = 0; i < 200; i++) begin
      @(posedge aclk); #1;
      if (wvalid && (w_total - base) == 2) break;
    end
    if (i == 200) miss("timeout_waiting_wbeat2");
    aresetn = 1'b0;
    #1;
    chk("async_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
    chk("async_rst_status", {busy, done, pass}, 3'd0);
    chk("async_rst_err", {err_count, err_addr}, 48'd0);
    q_aw.delete(); q_w.delete(); q_ar.delete(); q_res.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    run(s);

    // start during the read phase must be ignored
    clear_faults();
    s = 32'h0BAD_F00D;
    base = done_total;
    expect_test(s);
    pulse_start(s);
    for (i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (rready) break;
    end
    if (i == 500) miss("timeout_waiting_rdata");
    start = 1'b1;
    seed = 32'hFFFF_FFFF;
    @(negedge aclk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge aclk);
    chk("one_done_per_start", 32'(done_total - base), 32'd1);

    // randomized seeds, stalls and single faults
    for (int t = 0; t < 10; t++) begin
      int f;
      clear_faults();
      stall_en = int'($urandom_range(0, 1));
      f = int'($urandom_range(0, 3));
      if (f == 1) begin corrupt_b = int'($urandom_range(0, NB - 1)); corrupt_k = int'($urandom_range(0, BL - 1)); end
      if (f == 2) bresp_b = int'($urandom_range(0, NB - 1));
      if (f == 3) begin early_b = int'($urandom_range(0, NB - 1)); early_k = int'($urandom_range(0, BL - 2)); end
      run($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_mem_tester.md
AXI_MEM_TESTER -- requirements
Module: axi_mem_tester

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, start address of the test region (4 KiB aligned).
REQ-002 SHALL have parameter NUM_BURSTS, default 256, number of bursts per pass (1..65535).
REQ-003 SHALL have parameter BURST_LEN, default 16, beats per burst (1..16).
REQ-004 SHALL have port aclk, in, 1: the single clock.
REQ-005 SHALL have port aresetn, in, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, in, 1: one-cycle pulse that begins a test (ignored while busy).
REQ-007 SHALL have port seed, in, 32: pattern seed, sampled on an accepted start.
REQ-008 SHALL have ports busy/done/pass, out, 1 each: busy = test running; done = one-cycle pulse at completion; pass = last test had zero errors.
REQ-009 SHALL have ports err_count, out, 16 (saturating), and err_addr, out, 32 (address of the first mismatching beat).
REQ-010 SHALL have AXI4 master write ports awaddr 32, awlen 8, awsize 3, awburst 2, awvalid, awready(in), wdata 128, wstrb 16, wlast, wvalid, wready(in), bresp 2(in), bvalid(in), bready.
REQ-011 SHALL have AXI4 master read ports araddr 32, arlen 8, arsize 3, arburst 2, arvalid, arready(in), rdata 128(in), rresp 2(in), rlast(in), rvalid(in), rready.
REQ-012 SHALL drive the following outputs constant: awlen/arlen = BURST_LEN-1, awsize/arsize = 3'd4, awburst/arburst = INCR, wstrb = all ones, and lock/cache/prot/region/qos = 0.

Function
REQ-013 SHALL implement FSM states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN.
REQ-014 IDLE->WADDR on start; on that transition: burst index = 0, seed latched, err_count = 0, err_addr = 0, busy = 1.
REQ-015 Burst address SHALL be BASE_ADDR + idx*BURST_LEN*16 for both writes and reads.
REQ-016 Beat pattern SHALL be {4{seed ^ {idx[15:0], beat[15:0]}}}, where beat is 0..BURST_LEN-1 within the burst.
REQ-017 WADDR: awvalid=1 until awready; then WDATA.
REQ-018 WDATA: wvalid=1, beat advances on wvalid&wready; wlast=1 on beat BURST_LEN-1; after the last handshake go to WRESP.
REQ-019 WRESP: bready=1; on bvalid, bresp!=OKAY increments err_count; idx+1; next state is WADDR, or RADDR with idx=0 after burst NUM_BURSTS-1.
REQ-020 RADDR: arvalid=1 until arready; then RDATA.
REQ-021 RDATA: rready=1; each rvalid beat is compared to the REQ-016 pattern; a data mismatch or rresp!=OKAY increments err_count (saturating at 16'hFFFF); err_addr captures burst address + beat*16 only while err_count==0.
REQ-022 RDATA exits on an rlast beat: to RADDR with idx+1, or to FIN after the last burst. rlast asserted early SHALL end the burst and count as one error.
REQ-023 FIN: for one cycle, done=1 and pass=(err_count==0); busy=0; then IDLE.
REQ-024 valid signals SHALL NOT deassert before the corresponding ready; address/data SHALL be stable while valid and not ready.
REQ-025 Only one burst SHALL be outstanding; no write/read overlap.
REQ-026 start while busy SHALL have no effect; pass/err_count/err_addr SHALL hold until the next accepted start.

Reset
REQ-027 On aresetn low, the FSM SHALL enter IDLE immediately, including mid-burst (the downstream converter is reset by the same aresetn).
REQ-028 Reset values: all valid/ready outputs, busy, done, pass = 0; err_count = 0; err_addr = 0; idx = beat = 0.

Verification
REQ-029 NUM_BURSTS=2, BURST_LEN=4, ideal slave, seed=0 -> 2 write bursts at 0x00 and 0x40, then 2 read bursts; done pulse with pass=1, err_count=0.
REQ-030 Slave corrupts rdata of read burst 1, beat 2 -> err_count=1, err_addr=BASE+0x60, pass=0.
REQ-031 Random awready/wready/arready/rvalid stalls (50%) -> same result as REQ-029; no valid drops before ready (assertion).
REQ-032 bresp=SLVERR on burst 0 -> err_count=1, pass=0, read phase still runs.
REQ-033 aresetn pulsed low during WDATA beat 2 -> all outputs at reset values the same cycle; a new start completes with pass=1.
REQ-034 start pulsed during RDATA -> ignored; exactly one done pulse per accepted start.
